// File: rtl/sc_isa_pkg.sv
// Shared ISA definitions for the single-cycle CPU: mnemonic codes, opcode and
// func constants, loader FSM states and field-packing helpers.
package sc_isa_pkg;

    // Mnemonic codes presented to the loader; 21..31 are illegal
    localparam logic [4:0] MN_ADD  = 5'd0;
    localparam logic [4:0] MN_SUB  = 5'd1;
    localparam logic [4:0] MN_AND  = 5'd2;
    localparam logic [4:0] MN_OR   = 5'd3;
    localparam logic [4:0] MN_XOR  = 5'd4;
    localparam logic [4:0] MN_SLL  = 5'd5;
    localparam logic [4:0] MN_SRL  = 5'd6;
    localparam logic [4:0] MN_SRA  = 5'd7;
    localparam logic [4:0] MN_JR   = 5'd8;
    localparam logic [4:0] MN_LT   = 5'd9;
    localparam logic [4:0] MN_ADDI = 5'd10;
    localparam logic [4:0] MN_ANDI = 5'd11;
    localparam logic [4:0] MN_ORI  = 5'd12;
    localparam logic [4:0] MN_XORI = 5'd13;
    localparam logic [4:0] MN_LW   = 5'd14;
    localparam logic [4:0] MN_SW   = 5'd15;
    localparam logic [4:0] MN_BEQ  = 5'd16;
    localparam logic [4:0] MN_BNE  = 5'd17;
    localparam logic [4:0] MN_LUI  = 5'd18;
    localparam logic [4:0] MN_J    = 5'd19;
    localparam logic [4:0] MN_JAL  = 5'd20;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type func codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_LT  = 6'b000001;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        DONE = 2'd1,
        ERR  = 2'd2
    } state_t;

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] shamt,
                                          input logic [5:0] func);
        return {OP_RTYPE, rs, rt, rd, shamt, func};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imem_encoder_if.sv
// Symbolic-instruction stream into the program loader (valid/ready).
interface imem_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [25:0] in_imm;
    logic        in_last;

    modport master (
        output in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_last,
        output in_ready
    );
endinterface

// File: rtl/inst_encode.sv
// Combinational encoder: symbolic tuple -> 32-bit MIPS word plus illegal flag.
// Illegal mnemonics yield an all-zero word (NOP).
module inst_encode
    import sc_isa_pkg::*;
(
    input  logic [4:0]  mnem,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Field selection and forced-zero fields per mnemonic
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (mnem)
            MN_ADD:  word = enc_r(rs, rt, rd, 5'd0, FN_ADD);
            MN_SUB:  word = enc_r(rs, rt, rd, 5'd0, FN_SUB);
            MN_AND:  word = enc_r(rs, rt, rd, 5'd0, FN_AND);
            MN_OR:   word = enc_r(rs, rt, rd, 5'd0, FN_OR);
            MN_XOR:  word = enc_r(rs, rt, rd, 5'd0, FN_XOR);
            MN_LT:   word = enc_r(rs, rt, rd, 5'd0, FN_LT);
            MN_SLL:  word = enc_r(5'd0, rt, rd, shamt, FN_SLL);
            MN_SRL:  word = enc_r(5'd0, rt, rd, shamt, FN_SRL);
            MN_SRA:  word = enc_r(5'd0, rt, rd, shamt, FN_SRA);
            MN_JR:   word = enc_r(rs, 5'd0, 5'd0, 5'd0, FN_JR);
            MN_ADDI: word = enc_i(OP_ADDI, rs, rt, imm[15:0]);
            MN_ANDI: word = enc_i(OP_ANDI, rs, rt, imm[15:0]);
            MN_ORI:  word = enc_i(OP_ORI, rs, rt, imm[15:0]);
            MN_XORI: word = enc_i(OP_XORI, rs, rt, imm[15:0]);
            MN_LW:   word = enc_i(OP_LW, rs, rt, imm[15:0]);
            MN_SW:   word = enc_i(OP_SW, rs, rt, imm[15:0]);
            MN_BEQ:  word = enc_i(OP_BEQ, rs, rt, imm[15:0]);
            MN_BNE:  word = enc_i(OP_BNE, rs, rt, imm[15:0]);
            MN_LUI:  word = enc_i(OP_LUI, 5'd0, rt, imm[15:0]);
            MN_J:    word = {OP_J, imm};
            MN_JAL:  word = {OP_JAL, imm};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/imem_encoder.sv
// Program loader: encodes a stream of symbolic instructions and writes them to
// instruction memory from word 0 upward, holding the CPU in reset until done.
// Build option IMEM_ENC_CHECK_EN: reject illegal mnemonics (no write, go to ERR);
// otherwise they are written as NOP.
module imem_encoder
    import sc_isa_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    imem_encoder_if.slave     stream,
    input  logic              restart,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              stop_q;   // last/overflow word taken, its write still in flight
    logic              ovf_q;    // that in-flight word overflowed the memory
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              accept, wr_go, ill_err, at_end, restart_ok;

    inst_encode u_enc (
        .mnem    (stream.in_mnem),
        .rs      (stream.in_rs),
        .rt      (stream.in_rt),
        .rd      (stream.in_rd),
        .shamt   (stream.in_shamt),
        .imm     (stream.in_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // Acceptance stops as soon as the final word is taken, one cycle before
    // the state leaves LOAD, so in_ready also looks at the in-flight flag.
    assign stream.in_ready = (state_q == LOAD) && !stop_q;
    assign accept          = stream.in_valid && stream.in_ready;
    assign at_end          = (addr_q == ADDR_W'(DEPTH - 1));
    assign restart_ok      = restart && (state_q != LOAD);

`ifdef IMEM_ENC_CHECK_EN
    assign wr_go   = accept && !enc_illegal;
    assign ill_err = accept && enc_illegal;
`else
    assign wr_go   = accept;
    assign ill_err = 1'b0;
`endif

    assign done     = (state_q == DONE);
    assign err      = (state_q == ERR);
    assign cpu_hold = (state_q != DONE);

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= LOAD;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD: begin
                if (ill_err)     state_d = ERR;
                else if (stop_q) state_d = ovf_q ? ERR : DONE;
            end
            DONE, ERR: begin
                if (restart) state_d = LOAD;
            end
            default: state_d = LOAD;
        endcase
    end

    // Write register, address/count counters and in-flight flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            addr_q     <= '0;
            count      <= '0;
            stop_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            imem_we <= wr_go;
            if (wr_go) begin
                imem_addr  <= addr_q;
                imem_wdata <= enc_illegal ? '0 : enc_word;
                if (!at_end) addr_q <= addr_q + ADDR_W'(1);
                if (stream.in_last) begin
                    stop_q <= 1'b1;
                end else if (at_end) begin
                    stop_q <= 1'b1;
                    ovf_q  <= 1'b1;
                end
            end
            if (imem_we) count <= count + (ADDR_W + 1)'(1);
            if (restart_ok) begin
                addr_q    <= '0;
                count     <= '0;
                imem_addr <= '0;
                stop_q    <= 1'b0;
                ovf_q     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_imem_encoder.sv
// Self-checking bench for imem_encoder: table-driven encoding stream on a
// 64-word instance, plus hand sequences for restart, illegal mnemonic,
// asynchronous reset and overflow on a 4-word instance.
module tb_imem_encoder;
    import sc_isa_pkg::*;

    typedef struct {
        logic [4:0]  mnem;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [25:0] imm;
        logic        last;
        logic [31:0] word;
    } vec_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        restart_a, restart_b;
    logic        a_we, b_we, a_hold, b_hold, a_done, b_done, a_err, b_err;
    logic [5:0]  a_addr;
    logic [1:0]  b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic [6:0]  a_count;
    logic [2:0]  b_count;

    imem_encoder_if if_a ();
    imem_encoder_if if_b ();

    imem_encoder #(.ADDR_W(6)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .stream     (if_a),
        .restart    (restart_a),
        .imem_we    (a_we),
        .imem_addr  (a_addr),
        .imem_wdata (a_wdata),
        .cpu_hold   (a_hold),
        .done       (a_done),
        .err        (a_err),
        .count      (a_count)
    );

    imem_encoder #(.ADDR_W(2)) u_ovf (
        .clock      (clock),
        .reset      (reset),
        .stream     (if_b),
        .restart    (restart_b),
        .imem_we    (b_we),
        .imem_addr  (b_addr),
        .imem_wdata (b_wdata),
        .cpu_hold   (b_hold),
        .done       (b_done),
        .err        (b_err),
        .count      (b_count)
    );

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[13];
    vec_t v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_a(input vec_t t);
        if_a.in_valid = 1'b1;
        if_a.in_mnem  = t.mnem;
        if_a.in_rs    = t.rs;
        if_a.in_rt    = t.rt;
        if_a.in_rd    = t.rd;
        if_a.in_shamt = t.shamt;
        if_a.in_imm   = t.imm;
        if_a.in_last  = t.last;
    endtask

    task automatic drive_b(input vec_t t);
        if_b.in_valid = 1'b1;
        if_b.in_mnem  = t.mnem;
        if_b.in_rs    = t.rs;
        if_b.in_rt    = t.rt;
        if_b.in_rd    = t.rd;
        if_b.in_shamt = t.shamt;
        if_b.in_imm   = t.imm;
        if_b.in_last  = t.last;
    endtask

    task automatic idle_a();
        drive_a('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0});
        if_a.in_valid = 1'b0;
    endtask

    task automatic idle_b();
        drive_b('{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 26'd0, 1'b0, 32'd0});
        if_b.in_valid = 1'b0;
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_we"},    32'(a_we),         32'd0);
        check({tag, "_addr"},  32'(a_addr),       32'd0);
        check({tag, "_wdata"}, a_wdata,           32'd0);
        check({tag, "_hold"},  32'(a_hold),       32'd1);
        check({tag, "_done"},  32'(a_done),       32'd0);
        check({tag, "_err"},   32'(a_err),        32'd0);
        check({tag, "_count"}, 32'(a_count),      32'd0);
        check({tag, "_ready"}, 32'(if_a.in_ready), 32'd1);
    endtask

    // Hand-encoded add rs=1 rt=2 rd=<rd> for the small instance
    function automatic logic [31:0] add_word(input logic [4:0] rd);
        return {6'b000000, 5'd1, 5'd2, rd, 5'd0, 6'b100000};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{MN_ADD,  5'd1,  5'd2,  5'd3,  5'd0,  26'd0,        1'b0, 32'h00221820};
        vecs[1]  = '{MN_LW,   5'd29, 5'd5,  5'd0,  5'd0,  26'h000FFFC,  1'b0, 32'h8FA5FFFC};
        vecs[2]  = '{MN_SLL,  5'd7,  5'd1,  5'd2,  5'd4,  26'd0,        1'b0, 32'h00011100};
        vecs[3]  = '{MN_LT,   5'd5,  5'd6,  5'd4,  5'd0,  26'd0,        1'b0, 32'h00A62001};
        vecs[4]  = '{MN_SUB,  5'd8,  5'd9,  5'd10, 5'd3,  26'd0,        1'b0, 32'h01095022};
        vecs[5]  = '{MN_JR,   5'd31, 5'd3,  5'd4,  5'd5,  26'd0,        1'b0, 32'h03E00008};
        vecs[6]  = '{MN_LUI,  5'd7,  5'd8,  5'd0,  5'd0,  26'h0001234,  1'b0, 32'h3C081234};
        vecs[7]  = '{MN_SW,   5'd29, 5'd31, 5'd0,  5'd0,  26'h0000008,  1'b0, 32'hAFBF0008};
        vecs[8]  = '{MN_BEQ,  5'd1,  5'd2,  5'd0,  5'd0,  26'h000FFFF,  1'b0, 32'h1022FFFF};
        vecs[9]  = '{MN_SRA,  5'd3,  5'd4,  5'd5,  5'd31, 26'd0,        1'b0, 32'h00042FC3};
        vecs[10] = '{MN_ORI,  5'd2,  5'd3,  5'd0,  5'd0,  26'h3FFABCD,  1'b0, 32'h3443ABCD};
        vecs[11] = '{MN_J,    5'd0,  5'd0,  5'd0,  5'd0,  26'h3FFFFFF,  1'b0, 32'h0BFFFFFF};
        vecs[12] = '{MN_JAL,  5'd0,  5'd0,  5'd0,  5'd0,  26'h0000010,  1'b1, 32'h0C000010};

        reset = 1'b1;
        restart_a = 1'b0;
        restart_b = 1'b0;
        idle_a();
        idle_b();
        tick();
        tick();
        check_reset_a("reset");
        reset = 1'b0;

        // Back-to-back program, one write per accepted tuple, one cycle later
        for (int i = 0; i < 13; i++) begin
            drive_a(vecs[i]);
            tick();
            check($sformatf("v%0d_we", i),    32'(a_we),   32'd1);
            check($sformatf("v%0d_addr", i),  32'(a_addr), 32'(i));
            check($sformatf("v%0d_wdata", i), a_wdata,     vecs[i].word);
            check($sformatf("v%0d_ready", i), 32'(if_a.in_ready), (i == 12) ? 32'd0 : 32'd1);
            check($sformatf("v%0d_done", i),  32'(a_done), 32'd0);
        end
        idle_a();
        tick();
        check("fin_we",    32'(a_we),          32'd0);
        check("fin_done",  32'(a_done),        32'd1);
        check("fin_hold",  32'(a_hold),        32'd0);
        check("fin_ready", 32'(if_a.in_ready), 32'd0);
        check("fin_count", 32'(a_count),       32'd13);

        // Restart from DONE
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        check("rs_ready", 32'(if_a.in_ready), 32'd1);
        check("rs_done",  32'(a_done),        32'd0);
        check("rs_hold",  32'(a_hold),        32'd1);
        check("rs_count", 32'(a_count),       32'd0);
        v = '{MN_XOR, 5'd1, 5'd1, 5'd1, 5'd0, 26'd0, 1'b0, 32'h00210826};
        drive_a(v);
        tick();
        check("rs_w_addr",  32'(a_addr), 32'd0);
        check("rs_w_wdata", a_wdata,     v.word);

        // Restart while loading has no effect
        idle_a();
        restart_a = 1'b1;
        tick();
        restart_a = 1'b0;
        check("ign_count", 32'(a_count),       32'd1);
        check("ign_ready", 32'(if_a.in_ready), 32'd1);
        v = '{MN_ADDI, 5'd0, 5'd1, 5'd0, 5'd0, 26'h0000005, 1'b0, 32'h20010005};
        drive_a(v);
        tick();
        check("ign_w_addr",  32'(a_addr), 32'd1);
        check("ign_w_wdata", a_wdata,     v.word);
        idle_a();
        tick();
        check("strobe_once", 32'(a_we),    32'd0);
        check("ign_count2",  32'(a_count), 32'd2);

        // Illegal mnemonic
        v = '{5'd25, 5'd1, 5'd2, 5'd3, 5'd0, 26'h0001234, 1'b0, 32'd0};
        drive_a(v);
        tick();
        idle_a();
`ifdef IMEM_ENC_CHECK_EN
        check("ill_we",    32'(a_we),          32'd0);
        check("ill_err",   32'(a_err),         32'd1);
        check("ill_ready", 32'(if_a.in_ready), 32'd0);
        check("ill_hold",  32'(a_hold),        32'd1);
        tick();
        check("ill_we2",   32'(a_we),          32'd0);
`else
        check("ill_we",    32'(a_we),   32'd1);
        check("ill_addr",  32'(a_addr), 32'd2);
        check("ill_wdata", a_wdata,     32'd0);
        check("ill_err",   32'(a_err),  32'd0);
        tick();
`endif

        // Reset in the write cycle drops the write immediately
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive_a(vecs[0]);
        tick();
        idle_a();
        check("mid_we_pre", 32'(a_we), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_a("mid_async");
        tick();
        reset = 1'b0;
        check_reset_a("mid_held");

        // Overflow on the 4-word instance: fifth tuple never accepted
        for (int i = 0; i < 4; i++) begin
            drive_b('{MN_ADD, 5'd1, 5'd2, 5'(i), 5'd0, 26'd0, 1'b0, 32'd0});
            tick();
            check($sformatf("ov%0d_we", i),    32'(b_we),   32'd1);
            check($sformatf("ov%0d_addr", i),  32'(b_addr), 32'(i));
            check($sformatf("ov%0d_wdata", i), b_wdata,     add_word(5'(i)));
            check($sformatf("ov%0d_ready", i), 32'(if_b.in_ready), (i == 3) ? 32'd0 : 32'd1);
            check($sformatf("ov%0d_err", i),   32'(b_err),  32'd0);
        end
        drive_b('{MN_ADD, 5'd1, 5'd2, 5'd4, 5'd0, 26'd0, 1'b0, 32'd0});
        tick();
        check("ov_we",    32'(b_we),          32'd0);
        check("ov_err",   32'(b_err),         32'd1);
        check("ov_hold",  32'(b_hold),        32'd1);
        check("ov_ready", 32'(if_b.in_ready), 32'd0);
        tick();
        check("ov_we2",   32'(b_we),          32'd0);
        check("ov_count", 32'(b_count),       32'd4);
        idle_b();

        // Restart from ERR, then a program ending exactly in the last slot
        restart_b = 1'b1;
        tick();
        restart_b = 1'b0;
        check("ovr_err",   32'(b_err),         32'd0);
        check("ovr_count", 32'(b_count),       32'd0);
        check("ovr_ready", 32'(if_b.in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive_b('{MN_ADD, 5'd1, 5'd2, 5'(i + 8), 5'd0, 26'd0, (i == 3), 32'd0});
            tick();
            check($sformatf("fl%0d_addr", i),  32'(b_addr), 32'(i));
            check($sformatf("fl%0d_wdata", i), b_wdata,     add_word(5'(i + 8)));
        end
        idle_b();
        tick();
        check("fl_done",  32'(b_done),  32'd1);
        check("fl_err",   32'(b_err),   32'd0);
        check("fl_hold",  32'(b_hold),  32'd0);
        check("fl_count", 32'(b_count), 32'd4);
        check("fl_we",    32'(b_we),    32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
